// File: rtl/segmented_linear_processor_if.sv
// Command/status bundle between the opcode decoder, the segmented linear
// processor and the stepper/servo side.
interface segmented_linear_processor_if #(
    parameter int unsigned OP_BITS        = 4,
    parameter int unsigned ARG_BITS       = 12,
    parameter int unsigned STEPPER_X_BITS = 8,
    parameter int unsigned STEPPER_Y_BITS = 8,
    parameter int unsigned POS_BITS       = 16
);
    logic                             clk_en;
    logic                             trigger_in;
    logic                             done_in;
    logic [OP_BITS-1:0]               op;
    logic signed [ARG_BITS-1:0]       arg_x;
    logic signed [ARG_BITS-1:0]       arg_y;
    logic                             servo_pos;
    logic signed [STEPPER_X_BITS-1:0] num_steps_x;
    logic signed [STEPPER_Y_BITS-1:0] num_steps_y;
    logic                             trigger_out;
    logic                             done_out;
    logic signed [POS_BITS-1:0]       pos_x;
    logic signed [POS_BITS-1:0]       pos_y;

    modport master (
        output clk_en, trigger_in, done_in, op, arg_x, arg_y,
        input  servo_pos, num_steps_x, num_steps_y, trigger_out, done_out, pos_x, pos_y
    );

    modport slave (
        input  clk_en, trigger_in, done_in, op, arg_x, arg_y,
        output servo_pos, num_steps_x, num_steps_y, trigger_out, done_out, pos_x, pos_y
    );
endinterface

// File: rtl/segmented_linear_processor.sv
// G00/G01 linear move processor: tracks pen position, splits large moves into
// 2^k near-equal segments and hands each segment to the stepper with a trigger.
module segmented_linear_processor #(
    parameter int unsigned OP_BITS            = 4,
    parameter int unsigned ARG_BITS           = 12,
    parameter int unsigned STEPPER_X_BITS     = 8,
    parameter int unsigned STEPPER_Y_BITS     = 8,
    parameter int unsigned POS_BITS           = 16,
    parameter int unsigned SERVO_SETTLE_TICKS = 4,
    parameter logic [OP_BITS-1:0] OP_G00 = OP_BITS'(0),
    parameter logic [OP_BITS-1:0] OP_G01 = OP_BITS'(1),
    parameter logic [OP_BITS-1:0] OP_G90 = OP_BITS'(2),
    parameter logic [OP_BITS-1:0] OP_G91 = OP_BITS'(3)
) (
    input logic                          i_clk,
    input logic                          i_reset,
    segmented_linear_processor_if.slave  io_bus
);
    localparam int unsigned D_BITS   = POS_BITS + 1;
    localparam int unsigned E_BITS   = POS_BITS + 2;
    localparam int unsigned K_BITS   = $clog2(D_BITS + 1);
    localparam int unsigned CNT_BITS = (SERVO_SETTLE_TICKS > 1) ? $clog2(SERVO_SETTLE_TICKS) : 1;
    localparam int unsigned MAX_X    = (1 << (STEPPER_X_BITS - 1)) - 1;
    localparam int unsigned MAX_Y    = (1 << (STEPPER_Y_BITS - 1)) - 1;
    localparam logic        SERVO_UP   = 1'b0;
    localparam logic        SERVO_DOWN = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CALC,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t                      r_state;
    logic                        r_rel;
    logic                        r_servo;
    logic [STEPPER_X_BITS-1:0]   r_num_steps_x;
    logic [STEPPER_Y_BITS-1:0]   r_num_steps_y;
    logic                        r_trigger;
    logic                        r_done;
    logic [POS_BITS-1:0]         r_pos_x;
    logic [POS_BITS-1:0]         r_pos_y;
    logic [CNT_BITS-1:0]         r_cnt;
    logic [K_BITS-1:0]           r_k;
    logic [E_BITS-1:0]           r_idx;
    logic [D_BITS-1:0]           r_mag_x;
    logic [D_BITS-1:0]           r_mag_y;
    logic                        r_neg_x;
    logic                        r_neg_y;
    logic [D_BITS-1:0]           r_q_x;
    logic [D_BITS-1:0]           r_q_y;
    logic [D_BITS-1:0]           r_rem_x;
    logic [D_BITS-1:0]           r_rem_y;

    logic [D_BITS-1:0]           w_dx;
    logic [D_BITS-1:0]           w_dy;
    logic [D_BITS-1:0]           w_mag_dx;
    logic [D_BITS-1:0]           w_mag_dy;
    logic                        w_servo_req;
    logic                        w_is_move;
    logic [E_BITS-1:0]           w_pow;
    logic [E_BITS-1:0]           w_ceil_x;
    logic [E_BITS-1:0]           w_ceil_y;
    logic                        w_over;
    logic [D_BITS-1:0]           w_q_x;
    logic [D_BITS-1:0]           w_q_y;
    logic [D_BITS-1:0]           w_rem_x;
    logic [D_BITS-1:0]           w_rem_y;
    logic [E_BITS-1:0]           w_idx_next;
    logic                        w_last;

    // Signed step count for segment idx: the first rem segments carry one extra step.
    function automatic logic [D_BITS-1:0] seg_steps(input logic              neg,
                                                    input logic [D_BITS-1:0] q,
                                                    input logic [D_BITS-1:0] rem,
                                                    input logic [E_BITS-1:0] idx);
        logic [D_BITS-1:0] m;
        m = q + D_BITS'(idx < E_BITS'(rem));
        return neg ? (D_BITS'(0) - m) : m;
    endfunction

    always_comb begin
        w_dx        = r_rel ? D_BITS'(signed'(io_bus.arg_x))
                            : D_BITS'(signed'(io_bus.arg_x)) - D_BITS'(signed'(r_pos_x));
        w_dy        = r_rel ? D_BITS'(signed'(io_bus.arg_y))
                            : D_BITS'(signed'(io_bus.arg_y)) - D_BITS'(signed'(r_pos_y));
        w_mag_dx    = w_dx[D_BITS-1] ? (D_BITS'(0) - w_dx) : w_dx;
        w_mag_dy    = w_dy[D_BITS-1] ? (D_BITS'(0) - w_dy) : w_dy;
        w_servo_req = (io_bus.op == OP_G01) ? SERVO_DOWN : SERVO_UP;
        w_is_move   = (io_bus.op == OP_G00) || (io_bus.op == OP_G01);

        // ceil(|d| / 2^k) per axis decides whether k must grow.
        w_pow    = E_BITS'(1) << r_k;
        w_ceil_x = (E_BITS'(r_mag_x) + w_pow - E_BITS'(1)) >> r_k;
        w_ceil_y = (E_BITS'(r_mag_y) + w_pow - E_BITS'(1)) >> r_k;
        w_over   = (w_ceil_x > E_BITS'(MAX_X)) || (w_ceil_y > E_BITS'(MAX_Y));
        w_q_x    = r_mag_x >> r_k;
        w_q_y    = r_mag_y >> r_k;
        w_rem_x  = r_mag_x & D_BITS'(w_pow - E_BITS'(1));
        w_rem_y  = r_mag_y & D_BITS'(w_pow - E_BITS'(1));

        w_idx_next = r_idx + E_BITS'(1);
        w_last     = (w_idx_next == w_pow);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_rel         <= 1'b0;
            r_servo       <= SERVO_UP;
            r_num_steps_x <= '0;
            r_num_steps_y <= '0;
            r_trigger     <= 1'b0;
            r_done        <= 1'b1;
            r_pos_x       <= '0;
            r_pos_y       <= '0;
            r_cnt         <= '0;
            r_k           <= '0;
            r_idx         <= '0;
            r_mag_x       <= '0;
            r_mag_y       <= '0;
            r_neg_x       <= 1'b0;
            r_neg_y       <= 1'b0;
            r_q_x         <= '0;
            r_q_y         <= '0;
            r_rem_x       <= '0;
            r_rem_y       <= '0;
        end else if (io_bus.clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.trigger_in) begin
                        if (io_bus.op == OP_G90) begin
                            r_rel <= 1'b0;
                        end else if (io_bus.op == OP_G91) begin
                            r_rel <= 1'b1;
                        end else if (w_is_move) begin
                            r_done  <= 1'b0;
                            r_mag_x <= w_mag_dx;
                            r_mag_y <= w_mag_dy;
                            r_neg_x <= w_dx[D_BITS-1];
                            r_neg_y <= w_dy[D_BITS-1];
                            r_k     <= '0;
                            r_cnt   <= '0;
                            r_servo <= w_servo_req;
                            if ((w_servo_req != r_servo) && (SERVO_SETTLE_TICKS != 0)) begin
                                r_state <= S_SETTLE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == CNT_BITS'(SERVO_SETTLE_TICKS - 1)) begin
                        r_state <= S_CALC;
                    end else begin
                        r_cnt <= r_cnt + CNT_BITS'(1);
                    end
                end

                S_CALC: begin
                    if ((r_mag_x == '0) && (r_mag_y == '0)) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_over) begin
                        r_k <= r_k + K_BITS'(1);
                    end else begin
                        r_q_x         <= w_q_x;
                        r_q_y         <= w_q_y;
                        r_rem_x       <= w_rem_x;
                        r_rem_y       <= w_rem_y;
                        r_idx         <= '0;
                        r_num_steps_x <= STEPPER_X_BITS'(seg_steps(r_neg_x, w_q_x, w_rem_x, '0));
                        r_num_steps_y <= STEPPER_Y_BITS'(seg_steps(r_neg_y, w_q_y, w_rem_y, '0));
                        r_trigger     <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_trigger <= 1'b0;
                    r_state   <= S_WAIT_ACK;
                end

                // A stale high done_in must first drop before completion counts.
                S_WAIT_ACK: begin
                    if (!io_bus.done_in) begin
                        r_state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (io_bus.done_in) begin
                        r_pos_x <= r_pos_x + POS_BITS'(signed'(r_num_steps_x));
                        r_pos_y <= r_pos_y + POS_BITS'(signed'(r_num_steps_y));
                        r_idx   <= w_idx_next;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_num_steps_x <= STEPPER_X_BITS'(seg_steps(r_neg_x, r_q_x, r_rem_x, w_idx_next));
                            r_num_steps_y <= STEPPER_Y_BITS'(seg_steps(r_neg_y, r_q_y, r_rem_y, w_idx_next));
                            r_trigger     <= 1'b1;
                            r_state       <= S_ISSUE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.servo_pos   = r_servo;
    assign io_bus.num_steps_x = r_num_steps_x;
    assign io_bus.num_steps_y = r_num_steps_y;
    assign io_bus.trigger_out = r_trigger;
    assign io_bus.done_out    = r_done;
    assign io_bus.pos_x       = r_pos_x;
    assign io_bus.pos_y       = r_pos_y;

endmodule

// File: tb/tb_segmented_linear_processor.sv
// Directed bench for segmented_linear_processor: 4-bit stepper counts,
// 12-bit args, 16-bit position, clk_en active every other clock.
module tb_segmented_linear_processor;
    localparam logic [3:0] G00 = 4'd0;
    localparam logic [3:0] G01 = 4'd1;
    localparam logic [3:0] G90 = 4'd2;
    localparam logic [3:0] G91 = 4'd3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    segmented_linear_processor_if #(
        .OP_BITS(4), .ARG_BITS(12), .STEPPER_X_BITS(4), .STEPPER_Y_BITS(4), .POS_BITS(16)
    ) bus ();

    segmented_linear_processor #(
        .OP_BITS(4), .ARG_BITS(12), .STEPPER_X_BITS(4), .STEPPER_Y_BITS(4),
        .POS_BITS(16), .SERVO_SETTLE_TICKS(4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.clk_en = 1'b0;
        forever @(negedge clk) bus.clk_en = ~bus.clk_en;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next clk_en-qualified rising edge.
    task automatic tick();
        @(posedge clk);
        while (!bus.clk_en) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input int x, input int y);
        bus.op         = o;
        bus.arg_x      = 12'(x);
        bus.arg_y      = 12'(y);
        bus.trigger_in = 1'b1;
        tick();
        bus.trigger_in = 1'b0;
    endtask

    // One segment handshake, holding done_in stale-high for two extra ticks first.
    task automatic do_seg(input string tag, input int ex, input int ey, input int lat);
        int n;
        n = 0;
        while (!bus.trigger_out && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_trig"}, bus.trigger_out, 1);
        check({tag, "_lat"}, n, lat);
        check({tag, "_nx"}, bus.num_steps_x, ex);
        check({tag, "_ny"}, bus.num_steps_y, ey);
        tick();
        check({tag, "_trig_fall"}, bus.trigger_out, 0);
        tick();
        tick();
        check({tag, "_stale"}, bus.trigger_out, 0);
        check({tag, "_nx_hold"}, bus.num_steps_x, ex);
        check({tag, "_busy"}, bus.done_out, 0);
        bus.done_in = 1'b0;
        tick();
        bus.done_in = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_servo"}, bus.servo_pos, 0);
        check({tag, "_nx"}, bus.num_steps_x, 0);
        check({tag, "_ny"}, bus.num_steps_y, 0);
        check({tag, "_trig"}, bus.trigger_out, 0);
        check({tag, "_done"}, bus.done_out, 1);
        check({tag, "_px"}, bus.pos_x, 0);
        check({tag, "_py"}, bus.pos_y, 0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.trigger_in = 1'b0;
        bus.done_in    = 1'b1;
        bus.op         = G90;
        bus.arg_x      = '0;
        bus.arg_y      = '0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;
        tick();

        // G00 absolute (3,-4): no servo change, single segment, 2-tick latency
        issue(G00, 3, -4);
        check("t1_done_fall", bus.done_out, 0);
        check("t1_servo", bus.servo_pos, 0);
        do_seg("t1s0", 3, -4, 1);
        check("t1_done", bus.done_out, 1);
        check("t1_px", bus.pos_x, 3);
        check("t1_py", bus.pos_y, -4);

        // G01 absolute (20,-5): delta (17,-1), settle 4 + k=2 -> 4 segments
        issue(G01, 20, -5);
        check("t2_servo", bus.servo_pos, 1);
        check("t2_done_fall", bus.done_out, 0);
        do_seg("t2s0", 5, -1, 7);
        bus.op         = G00;
        bus.arg_x      = -12'sd100;
        bus.arg_y      = '0;
        bus.trigger_in = 1'b1;
        do_seg("t2s1", 4, 0, 0);
        bus.trigger_in = 1'b0;
        do_seg("t2s2", 4, 0, 0);
        do_seg("t2s3", 4, 0, 0);
        check("t2_done", bus.done_out, 1);
        check("t2_px", bus.pos_x, 20);
        check("t2_py", bus.pos_y, -5);
        check("t2_servo_hold", bus.servo_pos, 1);

        // G91 then zero-length G01: no trigger, servo stays down
        issue(G91, 0, 0);
        check("t3_g91_done", bus.done_out, 1);
        tick();
        check("t3_g91_done2", bus.done_out, 1);
        issue(G01, 0, 0);
        check("t3_zero_busy", bus.done_out, 0);
        check("t3_zero_trig", bus.trigger_out, 0);
        tick();
        check("t3_zero_done", bus.done_out, 1);
        check("t3_zero_trig2", bus.trigger_out, 0);
        tick();
        check("t3_zero_trig3", bus.trigger_out, 0);
        check("t3_servo", bus.servo_pos, 1);
        check("t3_px", bus.pos_x, 20);
        check("t3_py", bus.pos_y, -5);

        // Relative G01 (-30,2): k=3, q=(3,0) r=(6,2)
        issue(G01, -30, 2);
        do_seg("t4s0", -4, 1, 4);
        do_seg("t4s1", -4, 1, 0);
        do_seg("t4s2", -4, 0, 0);
        do_seg("t4s3", -4, 0, 0);
        do_seg("t4s4", -4, 0, 0);
        do_seg("t4s5", -4, 0, 0);
        do_seg("t4s6", -3, 0, 0);
        do_seg("t4s7", -3, 0, 0);
        check("t4_done", bus.done_out, 1);
        check("t4_px", bus.pos_x, -10);
        check("t4_py", bus.pos_y, -3);

        // Relative G01 (10,0): reset asserted mid-cycle in WAIT_DONE of segment 2
        issue(G01, 10, 0);
        do_seg("t5s0", 5, 0, 2);
        check("t5_px_mid", bus.pos_x, -5);
        check("t5s1_trig", bus.trigger_out, 1);
        check("t5s1_nx", bus.num_steps_x, 5);
        tick();
        bus.done_in = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t5_async_rst");
        bus.done_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // After reset mode is absolute: (2,2) then (3,1) -> second segment (1,-1)
        issue(G00, 2, 2);
        check("t6_servo", bus.servo_pos, 0);
        do_seg("t6s0", 2, 2, 1);
        check("t6_px", bus.pos_x, 2);
        check("t6_py", bus.pos_y, 2);
        issue(G00, 3, 1);
        do_seg("t6b", 1, -1, 1);
        check("t6b_px", bus.pos_x, 3);
        check("t6b_py", bus.pos_y, 1);
        check("t6b_done", bus.done_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/segmented_linear_processor.md
# segmented_linear_processor

Parametrised successor to the linear-move processor. Accepts G00/G01 moves with absolute (G90) or relative (G91) coordinates, tracks the current pen position, and splits any move too large for the stepper step-count width into 2^k near-equal segments, so G01 stays within one step of a straight line. It sits between the opcode decoder and the dual-axis stepper and servo controllers. It drives the servo with a settle delay and issues one stepper trigger per segment.

## Interface
- OP_BITS, `OP_BITS: opcode width.
- ARG_BITS, `ARG_BITS: signed coordinate argument width.
- STEPPER_X_BITS, `STEPPER_X_BITS: signed step-count width, X axis.
- STEPPER_Y_BITS, `STEPPER_Y_BITS: signed step-count width, Y axis.
- POS_BITS, 16: signed position register width; must be ≥ ARG_BITS.
- SERVO_SETTLE_TICKS, 4: clk_en ticks to wait after a servo position change.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  tick; all state advances only on clk rising edges where clk_en=1.
- trigger_in  in  1  new opcode valid; sampled in IDLE.
- done_in  in  1  downstream stepper idle (level).
- op  in  OP_BITS  Opcode_p op: OP_G00, OP_G01, OP_G90, OP_G91; others ignored.
- arg_x, arg_y  in  ARG_BITS  signed target/offset.
- servo_pos  out  Servo_p::ServoPosition_t  pen position.
- num_steps_x  out  STEPPER_X_BITS  signed segment steps, X.
- num_steps_y  out  STEPPER_Y_BITS  signed segment steps, Y.
- trigger_out  out  1  segment start.
- done_out  out  1  high when idle.
- pos_x, pos_y  out  POS_BITS  signed tracked position.

## Operation
- Reset values: servo_pos=SERVO_UP, num_steps_x/y=0, trigger_out=0, done_out=1, pos_x/y=0, mode=absolute. Reset mid-operation aborts immediately to these values.
- States: IDLE → SETTLE → CALC → ISSUE → WAIT_ACK → WAIT_DONE → (ISSUE | IDLE).
- IDLE, tick with trigger_in=1:
  - G90 sets absolute mode. G91 sets relative mode. done_out stays 1.
  - Unknown ops are ignored.
  - G00/G01: latch the op and args, clear done_out, and compute delta. Relative: delta = sign-extended arg. Absolute: delta = arg − pos. Delta width is POS_BITS+1.
  - Set servo_pos: G00→SERVO_UP, G01→SERVO_DOWN. If the value changed, go to SETTLE; otherwise go to CALC.
- SETTLE: count SERVO_SETTLE_TICKS ticks, then go to CALC.
- CALC: MAX_X = 2^(STEPPER_X_BITS−1)−1; MAX_Y likewise.
  - Start with k=0. Each tick, while ceil(|dx|/2^k) > MAX_X or ceil(|dy|/2^k) > MAX_Y, increment k.
  - Then S=2^k. Per axis: q=|d|>>k, r=|d| mod 2^k.
  - If dx=dy=0, return to IDLE with done_out=1 and no trigger.
- ISSUE, segment i (0..S−1): num_steps = sign(d)·(q + (i<r ? 1:0)) per axis. Assert trigger_out for exactly one tick period.
- WAIT_ACK: wait for done_in=0.
- WAIT_DONE: wait for done_in=1. Then add the segment to pos_x/pos_y and increment i. If i=S, go to IDLE and set done_out=1.
- trigger_in while not IDLE is ignored. The latched args are not affected by input changes.
- Position arithmetic wraps at POS_BITS (two's complement).

## Timing
- Every transition occurs on a clk edge qualified by clk_en. trigger_out rises on a tick and falls on the next tick.
- Minimum accept → first trigger_out latency is 2 ticks (IDLE→CALC→ISSUE with k=0). Each increment of k adds 1 tick. A servo change adds SERVO_SETTLE_TICKS.
- num_steps_x/y are stable from ISSUE through WAIT_DONE and hold their last value in IDLE.
- done_in still high after trigger (stale) never advances the FSM. A falling edge is required.
- done_out falls on the accept tick and rises on the tick the final WAIT_DONE completes.

## Test plan
Configuration: STEPPER_X/Y_BITS=4 (MAX=7), ARG_BITS=12, POS_BITS=16, period-2 clk_en.
- From reset, G00 (3,−4) with done_in pulsed low→high → servo UP, no settle, one segment (3,−4), pos=(3,−4), done_out=1.
- Then G01 absolute (20,−5) → servo DOWN, 4-tick settle, k=2. Segments (5,−1),(4,0),(4,0),(4,0). pos=(20,−5).
- G91, then G01 (0,0) → done_out=1 after G91. No trigger_out for G01. Servo stays DOWN. pos unchanged.
- After trigger_out, hold done_in high → FSM stays in WAIT_ACK and no further triggers occur. Lower then raise done_in → next segment issues.
- Pulse trigger_in with G00 (−100,0) during a busy G01 → ignored. The move completes with the original args.
- Assert reset during WAIT_DONE of segment 2 → all outputs return to reset values asynchronously. pos=(0,0), mode absolute.
